// File: rtl/sqrt_round_pack.sv
// ---------------------------------------------------------------------------
// sqrt_round_pack
//   Back end of the FP32 square-root datapath. Each fixed-point core result
//   (mant_in/sticky_in, qualified by done_in) is paired with the oldest
//   side-band tag (exponent, class, sign, NV, rounding mode) from an in-order
//   tag FIFO. The paired result is rounded, packed as IEEE-754 single and
//   written into a 2-entry skid buffer that drives a valid/ready port.
//
// Configuration macro:
//   SQRT_PACK_RM_EN  defined   -> tag_rm is stored per tag; RNE/RTZ/RDN/RUP/RMM
//                    undefined -> tag_rm ignored and not stored; RNE always
//
// Ports:
//   clk, rst (async, active low)
//   tag_valid/tag_exp/tag_class/tag_sign/tag_nv/tag_rm : tag push side
//   tag_full                                           : tag FIFO full
//   mant_in/sticky_in/done_in                          : core result side
//   out_valid/out_ready/out_data/out_flags             : packed result port
//                                                        flags = {NV,DZ,OF,UF,NX}
//   err_ovf : sticky, a result was dropped because the skid buffer was full
//   err_tag : sticky, tag pushed while full or done_in with no tag available
// ---------------------------------------------------------------------------
module sqrt_round_pack #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tag_valid,
  input  logic [7:0]       tag_exp,
  input  logic [1:0]       tag_class,
  input  logic             tag_sign,
  input  logic             tag_nv,
  input  logic [2:0]       tag_rm,
  output logic             tag_full,
  input  logic [WIDTH-1:0] mant_in,
  input  logic             sticky_in,
  input  logic             done_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_flags,
  output logic             err_ovf,
  output logic             err_tag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  // Bits of mant_in below the guard bit; all feed the sticky term.
  localparam logic [WIDTH-1:0] LO_MASK = WIDTH'((64'd1 << (WIDTH - 25)) - 64'd1);

  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  // ------------------------------------------------------------------
  // Tag FIFO
  // ------------------------------------------------------------------
  logic [7:0]    exp_mem  [DEPTH];
  logic [1:0]    cls_mem  [DEPTH];
  logic          sign_mem [DEPTH];
  logic          nv_mem   [DEPTH];
`ifdef SQRT_PACK_RM_EN
  logic [2:0]    rm_mem   [DEPTH];
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fifo_empty, fifo_full;
  logic          push, pop, tag_err;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    // done_in on an empty FIFO never pairs with a same-cycle push.
    pop        = done_in & ~fifo_empty;
    push       = tag_valid & (~fifo_full | pop);
    tag_err    = (tag_valid & fifo_full & ~pop) | (done_in & fifo_empty);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (push & ~pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop & ~push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      exp_mem[wr_ptr_q]  <= tag_exp;
      cls_mem[wr_ptr_q]  <= tag_class;
      sign_mem[wr_ptr_q] <= tag_sign;
      nv_mem[wr_ptr_q]   <= tag_nv;
`ifdef SQRT_PACK_RM_EN
      rm_mem[wr_ptr_q]   <= tag_rm;
`endif
    end
  end

`ifndef SQRT_PACK_RM_EN
  logic unused_rm;
  assign unused_rm = ^tag_rm;
`endif

  // ------------------------------------------------------------------
  // Round and pack (combinational, captured by the skid buffer)
  // ------------------------------------------------------------------
  logic [7:0]  h_exp;
  logic [1:0]  h_cls;
  logic        h_sign, h_nv;
  logic [2:0]  rm_sel;
  logic [22:0] frac;
  logic        g_bit, s_bit, nx, inc;
  logic [23:0] frac_sum;
  logic [8:0]  exp_sum;
  logic [31:0] res_data;
  logic [4:0]  res_flags;

  always_comb begin
    h_exp  = exp_mem[rd_ptr_q];
    h_cls  = cls_mem[rd_ptr_q];
    h_sign = sign_mem[rd_ptr_q];
    h_nv   = nv_mem[rd_ptr_q];
`ifdef SQRT_PACK_RM_EN
    rm_sel = rm_mem[rd_ptr_q];
`else
    rm_sel = RM_RNE;
`endif
    frac  = mant_in[WIDTH-2 -: 23];
    g_bit = mant_in[WIDTH-25];
    s_bit = (|(mant_in & LO_MASK)) | sticky_in;
    nx    = g_bit | s_bit;
    // sqrt results are never negative, so RDN behaves as truncation.
    case (rm_sel)
      RM_RTZ, RM_RDN: inc = 1'b0;
      RM_RUP:         inc = nx;
      RM_RMM:         inc = g_bit;
      default:        inc = g_bit & (s_bit | frac[0]);
    endcase
    // An all-ones fraction wraps to zero and the carry bumps the exponent.
    frac_sum = {1'b0, frac} + {23'd0, inc};
    exp_sum  = {1'b0, h_exp} + {8'd0, frac_sum[23]};

    res_data  = 32'h0;
    res_flags = 5'b00000;
    case (h_cls)
      CLS_NORM: begin
        if (exp_sum >= 9'd255) begin
          res_data  = POS_INF;
          res_flags = 5'b00101;
        end else begin
          res_data  = {1'b0, exp_sum[7:0], frac_sum[22:0]};
          res_flags = {4'b0000, nx};
        end
      end
      CLS_ZERO: res_data = {h_sign, 31'h0};
      CLS_INF:  res_data = POS_INF;
      default: begin
        res_data  = QNAN;
        res_flags = {h_nv, 4'b0000};
      end
    endcase
  end

  // ------------------------------------------------------------------
  // 2-entry skid buffer; entry 0 is the head presented on the port
  // ------------------------------------------------------------------
  logic [31:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [4:0]  e0_flags_q, e0_flags_d, e1_flags_q, e1_flags_d;
  logic [1:0]  sk_cnt_q, sk_cnt_d;
  logic        sk_pop, drop;
  logic        err_ovf_q, err_ovf_d, err_tag_q, err_tag_d;

  always_comb begin
    e0_data_d  = e0_data_q;
    e0_flags_d = e0_flags_q;
    e1_data_d  = e1_data_q;
    e1_flags_d = e1_flags_q;
    sk_cnt_d   = sk_cnt_q;
    sk_pop     = (sk_cnt_q != 2'd0) & out_ready;
    drop       = pop & (sk_cnt_q == 2'd2) & ~out_ready;

    if (sk_pop) begin
      e0_data_d  = e1_data_q;
      e0_flags_d = e1_flags_q;
    end
    if (pop & ~drop) begin
      // Slot the new result in behind whatever remains after the pop.
      if ((sk_cnt_q == 2'd0) || ((sk_cnt_q == 2'd1) && sk_pop)) begin
        e0_data_d  = res_data;
        e0_flags_d = res_flags;
      end else begin
        e1_data_d  = res_data;
        e1_flags_d = res_flags;
      end
    end
    sk_cnt_d = sk_cnt_q + {1'b0, pop & ~drop} - {1'b0, sk_pop};

    err_ovf_d = err_ovf_q | drop;
    err_tag_d = err_tag_q | tag_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      e0_data_q  <= 32'h0;
      e0_flags_q <= 5'b0;
      e1_data_q  <= 32'h0;
      e1_flags_q <= 5'b0;
      sk_cnt_q   <= 2'd0;
      err_ovf_q  <= 1'b0;
      err_tag_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      e0_data_q  <= e0_data_d;
      e0_flags_q <= e0_flags_d;
      e1_data_q  <= e1_data_d;
      e1_flags_q <= e1_flags_d;
      sk_cnt_q   <= sk_cnt_d;
      err_ovf_q  <= err_ovf_d;
      err_tag_q  <= err_tag_d;
    end
  end

  assign tag_full  = fifo_full;
  assign out_valid = (sk_cnt_q != 2'd0);
  assign out_data  = e0_data_q;
  assign out_flags = e0_flags_q;
  assign err_ovf   = err_ovf_q;
  assign err_tag   = err_tag_q;

endmodule

// File: tb/tb_sqrt_round_pack.sv
// ---------------------------------------------------------------------------
// tb_sqrt_round_pack
//   Scoreboard bench for sqrt_round_pack. A behavioural model (tag queue,
//   output occupancy count, arithmetic rounding) pushes expected results into
//   a queue; a monitor on the falling clock edge pops and compares whenever
//   the DUT transfers a result, and checks status outputs every cycle.
// ---------------------------------------------------------------------------
module tb_sqrt_round_pack;
  localparam int WIDTH = 26;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             tag_valid;
  logic [7:0]       tag_exp;
  logic [1:0]       tag_class;
  logic             tag_sign;
  logic             tag_nv;
  logic [2:0]       tag_rm;
  logic             tag_full;
  logic [WIDTH-1:0] mant_in;
  logic             sticky_in;
  logic             done_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_flags;
  logic             err_ovf;
  logic             err_tag;

  sqrt_round_pack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tag_valid(tag_valid), .tag_exp(tag_exp), .tag_class(tag_class),
    .tag_sign(tag_sign), .tag_nv(tag_nv), .tag_rm(tag_rm), .tag_full(tag_full),
    .mant_in(mant_in), .sticky_in(sticky_in), .done_in(done_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .err_ovf(err_ovf), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] e;
    logic [1:0] c;
    logic       s;
    logic       nv;
    logic [2:0] rm;
  } tag_t;

  tag_t        tq[$];
  logic [36:0] sbq[$];
  int          m_occ;
  logic        m_err_ovf, m_err_tag;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rounding: integer significand + remainder compared to one half.
  function automatic logic [36:0] ref_res(input tag_t t, input logic [WIDTH-1:0] m, input logic st);
    longint unsigned mv, q, lo, half;
    int              e, sh;
    logic [2:0]      rm;
    logic            up, inexact, above, tie;
    logic [31:0]     d;
    case (t.c)
      2'b01: return {t.s, 31'h0, 5'b00000};
      2'b10: return {32'h7F800000, 5'b00000};
      2'b11: return {32'h7FC00000, t.nv, 4'b0000};
      default: ;
    endcase
`ifdef SQRT_PACK_RM_EN
    rm = t.rm;
`else
    rm = 3'b000;
`endif
    sh      = WIDTH - 24;
    mv      = 64'(m);
    q       = mv >> sh;
    lo      = mv & ((64'd1 << sh) - 1);
    half    = 64'd1 << (sh - 1);
    inexact = (lo != 0) || st;
    above   = (lo > half) || ((lo == half) && st);
    tie     = (lo == half) && !st;
    case (rm)
      3'b001, 3'b010: up = 1'b0;
      3'b011:         up = inexact;
      3'b100:         up = (lo >= half);
      default:        up = above || (tie && q[0]);
    endcase
    q = q + 64'(up);
    e = int'(t.e);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {32'h7F800000, 5'b00101};
    d = {1'b0, 8'(e), q[22:0]};
    return {d, 4'b0000, inexact};
  endfunction

  // Behavioural model of the block, advanced on each active edge.
  always @(posedge clk or negedge rst) begin
    tag_t t;
    logic pop_t, full_t, xfer, acc;
    if (!rst) begin
      tq.delete();
      sbq.delete();
      m_occ     = 0;
      m_err_ovf = 1'b0;
      m_err_tag = 1'b0;
    end else begin
      pop_t  = done_in && (tq.size() > 0);
      full_t = (tq.size() == DEPTH);
      if (done_in && tq.size() == 0) m_err_tag = 1'b1;
      if (tag_valid && full_t && !pop_t) m_err_tag = 1'b1;
      xfer = (m_occ > 0) && out_ready;
      acc  = 1'b0;
      if (pop_t) begin
        t = tq.pop_front();
        if (m_occ == 2 && !out_ready) m_err_ovf = 1'b1;
        else begin
          sbq.push_back(ref_res(t, mant_in, sticky_in));
          acc = 1'b1;
        end
      end
      if (tag_valid && (!full_t || pop_t))
        tq.push_back('{e: tag_exp, c: tag_class, s: tag_sign, nv: tag_nv, rm: tag_rm});
      m_occ = m_occ + int'(acc) - int'(xfer);
    end
  end

  // Monitor: status every cycle, payload on each transfer.
  always @(negedge clk) begin
    logic [36:0] exp_r;
    check("out_valid", 64'(out_valid), 64'(m_occ > 0));
    check("tag_full", 64'(tag_full), 64'(tq.size() == DEPTH));
    check("err_ovf", 64'(err_ovf), 64'(m_err_ovf));
    check("err_tag", 64'(err_tag), 64'(m_err_tag));
    if (!rst) begin
      check("rst_out_data", 64'(out_data), 64'h0);
      check("rst_out_flags", 64'(out_flags), 64'h0);
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 64'(out_data), 64'hDEAD);
      end else begin
        exp_r = sbq.pop_front();
        check("out_data", 64'(out_data), 64'(exp_r[36:5]));
        check("out_flags", 64'(out_flags), 64'(exp_r[4:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tag_valid = 1'b0;
    done_in   = 1'b0;
  endtask

  task automatic set_tag(input logic [1:0] c, input logic [7:0] e, input logic s,
                         input logic nv, input logic [2:0] rm);
    tag_valid = 1'b1;
    tag_class = c;
    tag_exp   = e;
    tag_sign  = s;
    tag_nv    = nv;
    tag_rm    = rm;
  endtask

  task automatic set_done(input logic [WIDTH-1:0] m, input logic st);
    done_in   = 1'b1;
    mant_in   = m;
    sticky_in = st;
  endtask

  function automatic logic [WIDTH-1:0] rand_mant();
    logic [WIDTH-1:0] m;
    m = WIDTH'({$urandom, $urandom});
    if ($urandom_range(0, 7) == 0) m = '1;
    m[WIDTH-1] = 1'b1;
    return m;
  endfunction

  task automatic random_phase(input int n);
    logic [7:0] e;
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && tq.size() < DEPTH) begin
        c = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(0, 3));
        e = ($urandom_range(0, 9) == 0) ? 8'(254 + $urandom_range(0, 1)) : 8'($urandom_range(1, 254));
        set_tag(c, e, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 4)));
      end
      if ($urandom_range(0, 1) != 0 && tq.size() > 0) set_done(rand_mant(), 1'($urandom));
      tick();
    end
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2 && tq.size() > 0; i++) begin
      set_done(rand_mant(), 1'($urandom));
      tick();
    end
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b0; tag_valid = 1'b0; tag_exp = 8'h0; tag_class = 2'b00;
    tag_sign = 1'b0; tag_nv = 1'b0; tag_rm = 3'b000; mant_in = '0;
    sticky_in = 1'b0; done_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Exact 2.0 and sqrt(2) with sticky remainder.
    set_tag(2'b00, 8'h80, 1'b0, 1'b0, 3'b000); tick();
    set_done(26'h2000000, 1'b0); tick();
    tick(); tick();
    set_tag(2'b00, 8'h7F, 1'b0, 1'b0, 3'b000); tick();
    set_done(26'h2D413CC, 1'b1); tick();
    tick(); tick();

    // Rounding carry into the exponent, RNE then RTZ.
    set_tag(2'b00, 8'h7F, 1'b0, 1'b0, 3'b000); tick();
    set_tag(2'b00, 8'h7F, 1'b0, 1'b0, 3'b001); tick();
    set_done(26'h3FFFFFF, 1'b0); tick();
    set_done(26'h3FFFFFF, 1'b0); tick();
    tick(); tick();

    // Specials back to back.
    set_tag(2'b11, 8'h00, 1'b0, 1'b1, 3'b000); tick();
    set_tag(2'b01, 8'h00, 1'b1, 1'b0, 3'b000); tick();
    set_tag(2'b10, 8'h00, 1'b0, 1'b0, 3'b000); tick();
    for (int i = 0; i < 3; i++) begin set_done(rand_mant(), 1'b1); tick(); end
    tick(); tick();

    // Overflow of the skid buffer, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin set_tag(2'b00, 8'h81 + 8'(i), 1'b0, 1'b0, 3'b000); tick(); end
    for (int i = 0; i < 3; i++) begin set_done(rand_mant(), 1'($urandom)); tick(); end
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (5) tick();

    random_phase(1500);
    drain_all();

    // Fill the FIFO, push one more, then reset mid-stream.
    for (int i = 0; i < DEPTH; i++) begin set_tag(2'b00, 8'($urandom_range(1, 250)), 1'b0, 1'b0, 3'b000); tick(); end
    set_tag(2'b00, 8'h90, 1'b0, 1'b0, 3'b000); tick();
    tick();
    // Full FIFO with simultaneous push and pop is legal.
    set_tag(2'b00, 8'h91, 1'b0, 1'b0, 3'b000); set_done(rand_mant(), 1'b0); tick();
    set_done(rand_mant(), 1'b0); tick();
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // done_in on empty FIFO with a same-cycle push: no bypass.
    set_tag(2'b00, 8'h85, 1'b0, 1'b0, 3'b000); set_done(rand_mant(), 1'b0); tick();
    tick();
    set_done(26'h2000000, 1'b0); tick();
    tick(); tick();

    random_phase(1500);
    drain_all();
    repeat (6) tick();
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    check("tag_queue_empty", 64'(tq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
